// File: rtl/add_share_arb_pkg.sv
// Package shared by the add_share_arb slice.
// Contents:
//   DATA_W      - width of operands and result (16)
//   MAX_REQ     - largest supported requester count (8)
//   IDX_W       - index width for MAX_REQ requesters
//   arb_state_t - IDLE / EXEC / RESP state encoding
//   rr_pick()   - round-robin pick: first set bit at or after ptr, with wrap
package add_share_arb_pkg;

    localparam int DATA_W  = 16;
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

    // Scans num_req positions upward from ptr and wraps at num_req.
    // Returns 0 when no request is set; callers qualify with |req.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr,
        input int                 num_req
    );
        logic             found;
        logic [IDX_W-1:0] idx;
        rr_pick = '0;
        found   = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < num_req) begin
                idx = IDX_W'((int'(ptr) + k) % num_req);
                if (!found && req[idx]) begin
                    found   = 1'b1;
                    rr_pick = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/add_share_arb_rr_arbiter.sv
// Combinational round-robin arbiter used by add_share_arb.
// Ports:
//   req       - per-requester request vector
//   ptr       - round-robin start position (owned by the parent)
//   grant_oh  - one-hot grant, all zero when no request is set
//   grant_idx - index of the granted requester
//   grant_any - at least one request is set
module rr_arbiter
    import add_share_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_any
);

    logic [MAX_REQ-1:0] req_ext;
    logic [IDX_W-1:0]   pick;

    // NOTE: every variable gets a default before any conditional
    // assignment so that no path leaves it unassigned (no latch).
    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req;
        pick                 = rr_pick(req_ext, IDX_W'(ptr), NUM_REQ);
        grant_idx            = pick[ID_W-1:0];
        grant_any            = |req;
        grant_oh             = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/cla16.sv
// 16-bit adder mapped onto the CARRY4 chain.
// Ports:
//   a, b - 16-bit operands
//   cin  - carry in
//   sum  - (a + b + cin) mod 2^16; the carry out of bit 15 is not produced
module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum
);

    // Generate/propagate form, one bit per chain stage.
    always_comb begin
        logic carry;
        carry = cin;
        sum   = '0;
        for (int i = 0; i < 16; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | ((a[i] ^ b[i]) & carry);
        end
    end

endmodule

// File: rtl/add_share_arb.sv
// Shares one cla16 adder among NUM_REQ requesters with round-robin
// arbitration. One operation in flight: IDLE (grant) -> EXEC (add) ->
// RESP (hold result until rsp_ready).
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   req_valid  - per-requester request
//   req_ready  - one-hot accept strobe, combinational in the grant cycle
//   req_a/b    - operands, slice i = [16*i +: 16]
//   rsp_valid  - result available; rsp_ready - consumer accepts it
//   rsp_id     - requester that owns rsp_sum
//   rsp_sum    - (a + b) mod 2^16
//   busy       - state != IDLE
//   grant_cnt  - only with ADD_SHARE_ARB_STATS_EN: saturating 16-bit
//                grant count per requester, slice i = [16*i +: 16]
module add_share_arb
    import add_share_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_sum,
    output logic                      busy
`ifdef ADD_SHARE_ARB_STATS_EN
    ,
    output logic [NUM_REQ*DATA_W-1:0] grant_cnt
`endif
);

    arb_state_t          state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     op_id;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [DATA_W-1:0]   sum;
    logic [NUM_REQ-1:0]  grant_oh;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_any;
    logic                grant_fire;
    logic [ID_W-1:0]     ptr_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Adder sees registered operands only.
    cla16 u_add (
        .a   (op_a),
        .b   (op_b),
        .cin (1'b0),
        .sum (sum)
    );

    // Gated by rst so req_ready reads 0 while reset is held.
    assign grant_fire = (state == IDLE) && grant_any && !rst;
    assign req_ready  = grant_fire ? grant_oh : '0;
    assign busy       = (state != IDLE);
    assign ptr_next   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            // NOTE: operand registers are always written before use, but
            // are reset anyway; they are few and it keeps the state clean.
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        op_a   <= req_a[grant_idx*DATA_W +: DATA_W];
                        op_b   <= req_b[grant_idx*DATA_W +: DATA_W];
                        op_id  <= grant_idx;
                        rr_ptr <= ptr_next;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_sum   <= sum;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADD_SHARE_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt <= '0;
        end else if (grant_fire) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_oh[i] && (grant_cnt[i*DATA_W +: DATA_W] != {DATA_W{1'b1}})) begin
                    grant_cnt[i*DATA_W +: DATA_W] <= grant_cnt[i*DATA_W +: DATA_W] + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_add_share_arb.sv
// Directed self-checking bench for add_share_arb (NUM_REQ = 4).
// Covers reset, single op, wrap-around sums, round-robin fairness and
// spacing, response backpressure and reset during EXEC. The grant counter
// check is compiled in when ADD_SHARE_ARB_STATS_EN is defined.
module tb_add_share_arb;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*16-1:0] req_a = '0;
    logic [NUM_REQ*16-1:0] req_b = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [ID_W-1:0]      rsp_id;
    logic [15:0]          rsp_sum;
    logic                 busy;
`ifdef ADD_SHARE_ARB_STATS_EN
    logic [NUM_REQ*16-1:0] grant_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    add_share_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .busy      (busy)
`ifdef ADD_SHARE_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
    endtask

    // Waits (bounded) until some req_ready is high; returns the cycle stamp.
    task automatic wait_grant(output int at);
        int n;
        n = 0;
        #1;
        while (req_ready == '0 && n < 20) begin
            tick();
            n++;
        end
        if (req_ready == '0) check("grant_timeout", 32'd0, 32'd1);
        at = cyc;
    endtask

    // One complete operation for requester i with rsp_ready held high.
    task automatic run_one(input string tag, input int i, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] exp_sum);
        int t;
        set_op(i, a, b);
        req_valid = NUM_REQ'(1) << i;
        wait_grant(t);
        check({tag, "_ready"}, 32'(req_ready), 32'(NUM_REQ'(1) << i));
        tick();
        req_valid = '0;
        tick();
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_id"}, 32'(rsp_id), 32'(i));
        check({tag, "_sum"}, 32'(rsp_sum), 32'(exp_sum));
        tick();
    endtask

    initial begin
        int t;
        int prev;
        logic [15:0] hold_sum;

        // Reset state
        repeat (3) tick();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_no_req_busy", 32'(busy), 32'd0);

        // Single request, cycle-by-cycle
        set_op(0, 16'h1234, 16'h0FF0);
        req_valid = 4'b0001;
        #1;
        check("single_ready", 32'(req_ready), 32'h1);
        check("single_busy_idle", 32'(busy), 32'd0);
        tick();
        req_valid = '0;
        #1;
        check("single_exec_ready", 32'(req_ready), 32'h0);
        check("single_exec_busy", 32'(busy), 32'd1);
        check("single_exec_valid", 32'(rsp_valid), 32'd0);
        tick();
        check("single_rsp_valid", 32'(rsp_valid), 32'd1);
        check("single_rsp_id", 32'(rsp_id), 32'd0);
        check("single_rsp_sum", 32'(rsp_sum), 32'h2224);
        rsp_ready = 1'b1;
        tick();
        check("single_done_valid", 32'(rsp_valid), 32'd0);
        check("single_done_busy", 32'(busy), 32'd0);

        // Wrap-around sums (rr_ptr walks 1 -> 2 -> 3 -> 0)
        run_one("wrap_ffff", 1, 16'hFFFF, 16'h0001, 16'h0000);
        run_one("wrap_8000", 2, 16'h8000, 16'h8000, 16'h0000);
        run_one("plain", 3, 16'hABCD, 16'h1111, 16'hBCDE);

        // Fairness: all requesting, expect 0,1,2,3,0 spaced 3 cycles
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 16'(16'h1000 * (i + 1)), 16'(16'h0100 + i));
        req_valid = 4'b1111;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant(t);
            check("fair_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            if (k > 0) check("fair_spacing", 32'(t - prev), 32'd3);
            prev = t;
            tick();
            tick();
            check("fair_id", 32'(rsp_id), 32'(k % 4));
            check("fair_sum", 32'(rsp_sum), 32'(16'h1000 * ((k % 4) + 1) + 16'h0100 + (k % 4)));
            tick();
        end

        // Backpressure: grant goes to 1, response held for 5 cycles
        rsp_ready = 1'b0;
        wait_grant(t);
        check("bp_grant", 32'(req_ready), 32'h2);
        tick();
        tick();
        check("bp_valid", 32'(rsp_valid), 32'd1);
        hold_sum = rsp_sum;
        check("bp_sum", 32'(hold_sum), 32'h2101);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_sum", 32'(rsp_sum), 32'h2101);
            check("bp_hold_id", 32'(rsp_id), 32'd1);
            check("bp_hold_ready", 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(rsp_valid), 32'd0);
        check("bp_next_grant", 32'(req_ready), 32'h4);

        // Reset during EXEC
        tick();
        check("mid_exec_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_ready_held", 32'(req_ready), 32'h0);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_grant", 32'(req_ready), 32'h1);
        tick();
        tick();
        check("mid_rst_id", 32'(rsp_id), 32'd0);
        check("mid_rst_sum", 32'(rsp_sum), 32'h1100);
        tick();
        req_valid = '0;

`ifdef ADD_SHARE_ARB_STATS_EN
        // Saturating grant counter
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("stats_rst", 32'(grant_cnt[31:0]), 32'h0);
        req_valid = 4'b0010;
        for (int k = 0; k < 70000; k++) begin
            wait_grant(t);
            tick();
            tick();
            tick();
        end
        req_valid = '0;
        #1;
        check("stats_sat", 32'(grant_cnt[31:16]), 32'hFFFF);
        check("stats_slice0", 32'(grant_cnt[15:0]), 32'h0);
        check("stats_slice2", 32'(grant_cnt[47:32]), 32'h0);
        check("stats_slice3", 32'(grant_cnt[63:48]), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
